// File: rtl/cla_word_sequencer.sv
// cla_word_sequencer
//   Drives one shared 8-bit carry-lookahead adder for NBYTES consecutive
//   cycles to build an 8*NBYTES-bit add/subtract, least-significant byte
//   first, chaining the carry through an internal register.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready   request handshake; req_sub, req_a, req_b, req_cin
//                         are captured on the accepting edge
//   add_a/add_b/add_cin   byte operands to the external adder (0 outside RUN)
//   add_sum/add_cout      same-cycle combinational adder result
//   rsp_valid/rsp_ready   response handshake; rsp_sum, rsp_cout, rsp_ovf
//                         are held stable while the response is pending
//   busy                  high while an operation is running or awaiting
//                         its response handshake
module cla_word_sequencer #(
   parameter int unsigned NBYTES = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_sub,
   input  logic [8*NBYTES-1:0]   req_a,
   input  logic [8*NBYTES-1:0]   req_b,
   input  logic                  req_cin,
   output logic [7:0]            add_a,
   output logic [7:0]            add_b,
   output logic                  add_cin,
   input  logic [7:0]            add_sum,
   input  logic                  add_cout,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [8*NBYTES-1:0]   rsp_sum,
   output logic                  rsp_cout,
   output logic                  rsp_ovf,
   output logic                  busy
);

   localparam int unsigned W  = 8 * NBYTES;
   localparam int unsigned IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic            carry_q, carry_d;
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    b_q, b_d;
   logic [W-1:0]    res_q, res_d;
   logic [W-1:0]    rsp_sum_q, rsp_sum_d;
   logic            rsp_cout_q, rsp_cout_d;
   logic            rsp_ovf_q, rsp_ovf_d;
   logic [7:0]      a_byte, b_byte;

   // State register and datapath flops
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         carry_q    <= 1'b0;
         a_q        <= '0;
         b_q        <= '0;
         res_q      <= '0;
         rsp_sum_q  <= '0;
         rsp_cout_q <= 1'b0;
         rsp_ovf_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         carry_q    <= carry_d;
         a_q        <= a_d;
         b_q        <= b_d;
         res_q      <= res_d;
         rsp_sum_q  <= rsp_sum_d;
         rsp_cout_q <= rsp_cout_d;
         rsp_ovf_q  <= rsp_ovf_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (req_valid && req_ready) state_d = RUN;
         RUN:     if (idx_q == LAST)          state_d = DONE;
         DONE:    if (rsp_ready)              state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Byte selection from the captured operands
   always_comb begin
      a_byte = a_q[8*int'(idx_q) +: 8];
      b_byte = b_q[8*int'(idx_q) +: 8];
   end

   // Datapath next values
   always_comb begin
      idx_d      = idx_q;
      carry_d    = carry_q;
      a_d        = a_q;
      b_d        = b_q;
      res_d      = res_q;
      rsp_sum_d  = rsp_sum_q;
      rsp_cout_d = rsp_cout_q;
      rsp_ovf_d  = rsp_ovf_q;
      unique case (state_q)
         IDLE: begin
            if (req_valid && req_ready) begin
               a_d     = req_a;
               // Subtract is A + ~B + 1; a set borrow-in cancels the +1.
               b_d     = req_sub ? ~req_b : req_b;
               carry_d = req_cin ^ req_sub;
               idx_d   = '0;
            end
         end
         RUN: begin
            res_d[8*int'(idx_q) +: 8] = add_sum;
            carry_d = add_cout;
            if (idx_q == LAST) begin
               idx_d = '0;
               // Published only on completion so rsp_sum never shows a
               // partially built word of a later operation.
               rsp_sum_d  = res_d;
               rsp_cout_d = add_cout;
               // Carry into bit 7 is a^b^sum there; overflow when it
               // differs from the carry out of bit 7.
               rsp_ovf_d  = add_cout ^ (a_byte[7] ^ b_byte[7] ^ add_sum[7]);
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Outputs
   always_comb begin
      req_ready = rst_n && (state_q == IDLE);
      rsp_valid = (state_q == DONE);
      busy      = (state_q == RUN) || (state_q == DONE);
      add_a     = '0;
      add_b     = '0;
      add_cin   = 1'b0;
      if (state_q == RUN) begin
         add_a   = a_byte;
         add_b   = b_byte;
         add_cin = carry_q;
      end
      rsp_sum  = rsp_sum_q;
      rsp_cout = rsp_cout_q;
      rsp_ovf  = rsp_ovf_q;
   end

endmodule
